// File: rtl/diffeq_controller.sv
// Sequencing FSM for the differential-equation solver datapath: operand loads, four compute phases per iteration.
// Optional DIFFEQ_ITER_LIMIT_EN: bound the loop at MAX_ITER iterations and flag iter_overflow.
//
// state     | meaning
// IDLE      | waiting for start
// READ      | loading x, dx, a, u from the input bus
// COMPUTE_1 | datapath phase 1
// COMPUTE_2 | datapath phase 2
// COMPUTE_3 | datapath phase 3
// COMPUTE_4 | datapath phase 4, loop decision
// DONE      | one-cycle completion
module diffeq_controller #(
   parameter int MAX_ITER = 255,
   parameter int ITER_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic              compute_done,
   input  logic              continue_while,
   output logic [2:0]        state,
   output logic              load_x,
   output logic              load_dx,
   output logic              load_a,
   output logic              load_u,
   output logic              busy,
   output logic              done,
   output logic [ITER_W-1:0] iter_count,
   output logic              iter_overflow
);

   typedef enum logic [2:0] {
      IDLE      = 3'b000,
      READ      = 3'b001,
      COMPUTE_1 = 3'b010,
      COMPUTE_2 = 3'b011,
      COMPUTE_3 = 3'b100,
      COMPUTE_4 = 3'b101,
      DONE      = 3'b110
   } state_t;

   state_t            cur, nxt;
   logic [1:0]        idx, idx_nxt;
   logic [ITER_W-1:0] cnt_nxt;
   logic              limit_hit;

`ifdef DIFFEQ_ITER_LIMIT_EN
   logic ovf_q, ovf_nxt;
   // Widened by one bit so the +1 compare never wraps.
   assign limit_hit = ({1'b0, iter_count} + 1'b1) >= (ITER_W+1)'(MAX_ITER);
   assign iter_overflow = ovf_q;
`else
   assign limit_hit = 1'b0;
   assign iter_overflow = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur        <= IDLE;
         idx        <= 2'd0;
         iter_count <= '0;
      end else begin
         cur        <= nxt;
         idx        <= idx_nxt;
         iter_count <= cnt_nxt;
      end
   end

`ifdef DIFFEQ_ITER_LIMIT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) ovf_q <= 1'b0;
      else       ovf_q <= ovf_nxt;
   end
`endif

   always_comb begin
      nxt     = cur;
      idx_nxt = idx;
      cnt_nxt = iter_count;
`ifdef DIFFEQ_ITER_LIMIT_EN
      ovf_nxt = ovf_q;
`endif
      load_x  = 1'b0;
      load_dx = 1'b0;
      load_a  = 1'b0;
      load_u  = 1'b0;
      done    = 1'b0;
      case (cur)
         IDLE: begin
            if (start) begin
               nxt     = READ;
               idx_nxt = 2'd0;
               cnt_nxt = '0;
`ifdef DIFFEQ_ITER_LIMIT_EN
               ovf_nxt = 1'b0;
`endif
            end
         end
         READ: begin
            load_x  = in_valid & (idx == 2'd0);
            load_dx = in_valid & (idx == 2'd1);
            load_a  = in_valid & (idx == 2'd2);
            load_u  = in_valid & (idx == 2'd3);
            if (in_valid) begin
               idx_nxt = idx + 2'd1;
               if (idx == 2'd3) nxt = COMPUTE_1;
            end
         end
         COMPUTE_1: if (compute_done) nxt = COMPUTE_2;
         COMPUTE_2: if (compute_done) nxt = COMPUTE_3;
         COMPUTE_3: if (compute_done) nxt = COMPUTE_4;
         COMPUTE_4: begin
            if (compute_done) begin
               cnt_nxt = iter_count + 1'b1;
               if (continue_while && !limit_hit) begin
                  nxt = COMPUTE_1;
               end else begin
                  nxt = DONE;
`ifdef DIFFEQ_ITER_LIMIT_EN
                  if (continue_while) begin
                     ovf_nxt = 1'b1;
                     cnt_nxt = ITER_W'(MAX_ITER);
                  end
`endif
               end
            end
         end
         DONE: begin
            done = 1'b1;
            nxt  = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   assign state = cur;
   assign busy  = (cur != IDLE);

endmodule
